// File: rtl/my_lib.sv
// Shared MDU types: operation codes, controller states and default latencies.
package my_lib;

    localparam int unsigned XLEN                = 32;
    localparam int unsigned CNT_W               = 4;
    localparam int unsigned MUL_LATENCY_DEFAULT = 5;
    localparam int unsigned DIV_LATENCY_DEFAULT = 10;

    typedef enum logic [3:0] {
        MDU_NONE,
        MDU_READ_HI,
        MDU_READ_LO,
        MDU_WRITE_HI,
        MDU_WRITE_LO,
        MDU_MULT,
        MDU_MULTU,
        MDU_DIV,
        MDU_DIVU
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE,
        MDU_RUN
    } mdu_state_e;

    function automatic logic is_start_op(input mdu_op_e op);
        return op > MDU_WRITE_LO;
    endfunction

    function automatic logic is_read_op(input mdu_op_e op);
        return (op != MDU_NONE) && (op < MDU_WRITE_HI);
    endfunction

    function automatic logic is_div_op(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_controller_if.sv
// EX-stage <-> MDU handshake bundle; the controller sits on the slave side.
interface mdu_controller_if;

    logic               op_valid;
    my_lib::mdu_op_e    op;
    logic [31:0]        operand_a;
    logic [31:0]        operand_b;
    logic               cancel;
    logic               op_ready;
    logic               stall;
    logic               busy;
    logic               done;
    logic [31:0]        read_data;
    logic [31:0]        hi;
    logic [31:0]        lo;

    modport master (
        output op_valid, op, operand_a, operand_b, cancel,
        input  op_ready, stall, busy, done, read_data, hi, lo
    );

    modport slave (
        input  op_valid, op, operand_a, operand_b, cancel,
        output op_ready, stall, busy, done, read_data, hi, lo
    );

endinterface

// File: rtl/mdu_result_calc.sv
// Combinational 64-bit HI/LO result for MULT/MULTU/DIV/DIVU, plus divide-by-zero flag.
module mdu_result_calc
    import my_lib::*;
(
    input  mdu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi_c,
    output logic [XLEN-1:0] lo_c,
    output logic            div_zero_c
);

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic              neg_a;
    logic              neg_b;

    // Signed divide runs on magnitudes so INT_MIN / -1 wraps to INT_MIN with no trap.
    always_comb begin
        hi_c       = '0;
        lo_c       = '0;
        div_zero_c = 1'b0;
        prod       = '0;
        neg_a      = (op == MDU_DIV) && a[XLEN-1];
        neg_b      = (op == MDU_DIV) && b[XLEN-1];
        mag_a      = neg_a ? -a : a;
        mag_b      = neg_b ? -b : b;
        quo        = '0;
        rem        = '0;
        case (op)
            MDU_MULT: begin
                prod = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
                {hi_c, lo_c} = prod;
            end
            MDU_MULTU: begin
                prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
                {hi_c, lo_c} = prod;
            end
            MDU_DIV, MDU_DIVU: begin
                div_zero_c = (b == '0);
                if (!div_zero_c) begin
                    quo = mag_a / mag_b;
                    rem = mag_a % mag_b;
                end
                lo_c = (neg_a ^ neg_b) ? -quo : quo;
                hi_c = neg_a ? -rem : rem;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_controller.sv
// EX-stage multiply/divide sequencer: owns HI/LO, the busy counter and the hazard stall.
module mdu_controller
    import my_lib::*;
#(
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEFAULT,
    parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    mdu_controller_if.slave bus
);

    mdu_state_e       state;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  stage_hi;
    logic [XLEN-1:0]  stage_lo;
    logic             stage_dz;
    logic             busy_q;
    logic             done_q;

    logic [XLEN-1:0]  calc_hi_c;
    logic [XLEN-1:0]  calc_lo_c;
    logic             calc_dz_c;
    logic             is_mdu_c;
    logic             accept_c;

    mdu_result_calc u_calc (
        .op         (bus.op),
        .a          (bus.operand_a),
        .b          (bus.operand_b),
        .hi_c       (calc_hi_c),
        .lo_c       (calc_lo_c),
        .div_zero_c (calc_dz_c)
    );

    assign is_mdu_c      = bus.op_valid && (bus.op != MDU_NONE);
    assign accept_c      = is_mdu_c && (state == MDU_IDLE) && !bus.cancel;
    assign bus.op_ready  = accept_c;
    assign bus.stall     = is_mdu_c && (state == MDU_RUN);
    assign bus.read_data = (accept_c && is_read_op(bus.op))
                           ? ((bus.op == MDU_READ_HI) ? hi_q : lo_q) : '0;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // Cancel in RUN takes priority over the commit on the count==0 cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= MDU_IDLE;
            count    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            stage_hi <= '0;
            stage_lo <= '0;
            stage_dz <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                MDU_IDLE: begin
                    if (accept_c) begin
                        if (bus.op == MDU_WRITE_HI) hi_q <= bus.operand_a;
                        if (bus.op == MDU_WRITE_LO) lo_q <= bus.operand_a;
                        if (is_start_op(bus.op)) begin
                            stage_hi <= calc_hi_c;
                            stage_lo <= calc_lo_c;
                            stage_dz <= calc_dz_c;
                            count    <= is_div_op(bus.op) ? CNT_W'(DIV_LATENCY - 1)
                                                          : CNT_W'(MUL_LATENCY - 1);
                            state    <= MDU_RUN;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                MDU_RUN: begin
                    if (bus.cancel) begin
                        state    <= MDU_IDLE;
                        busy_q   <= 1'b0;
                        stage_hi <= '0;
                        stage_lo <= '0;
                        stage_dz <= 1'b0;
                        count    <= '0;
                    end else if (count == '0) begin
                        state  <= MDU_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        if (!stage_dz) begin
                            hi_q <= stage_hi;
                            lo_q <= stage_lo;
                        end
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_controller.sv
// Scoreboard bench for mdu_controller: directed scenarios plus randomized op streams.
module tb_mdu_controller;
    import my_lib::*;

    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned DIV_LAT = 10;

    typedef struct {
        bit          is_read;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] data;
    } exp_t;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    exp_t sbq[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_controller_if bus ();

    mdu_controller #(
        .MUL_LATENCY (MUL_LAT),
        .DIV_LATENCY (DIV_LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Reference model: architectural effect computed with plain 64-bit arithmetic.
    task automatic model_apply(input mdu_op_e o, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        int     ia;
        int     ib;
        longint p;
        longint q;
        longint r;
        ia = int'(a);
        ib = int'(b);
        e  = '{is_read: 1'b0, hi: 32'h0, lo: 32'h0, data: 32'h0};
        case (o)
            MDU_READ_HI, MDU_READ_LO: begin
                e.is_read = 1'b1;
                e.data    = (o == MDU_READ_HI) ? m_hi : m_lo;
                sbq.push_back(e);
            end
            MDU_WRITE_HI: m_hi = a;
            MDU_WRITE_LO: m_lo = a;
            default: begin
                if (o == MDU_MULT) begin
                    p = longint'(ia) * longint'(ib);
                    m_hi = p[63:32];
                    m_lo = p[31:0];
                end else if (o == MDU_MULTU) begin
                    p = longint'({32'h0, a}) * longint'({32'h0, b});
                    m_hi = p[63:32];
                    m_lo = p[31:0];
                end else if (b != 32'h0) begin
                    if (o == MDU_DIV) begin
                        q = longint'(ia) / longint'(ib);
                        r = longint'(ia) % longint'(ib);
                    end else begin
                        q = longint'({32'h0, a}) / longint'({32'h0, b});
                        r = longint'({32'h0, a}) % longint'({32'h0, b});
                    end
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
                e.hi = m_hi;
                e.lo = m_lo;
                sbq.push_back(e);
            end
        endcase
    endtask

    // Present an op from posedge+1 until accepted; returns the number of stalled cycles.
    task automatic issue(input mdu_op_e o, input logic [31:0] a, input logic [31:0] b,
                         input bit use_model, output int stalls);
        int waited;
        stalls = 0;
        waited = 0;
        if (use_model) model_apply(o, a, b);
        bus.op_valid  = 1'b1;
        bus.op        = o;
        bus.operand_a = a;
        bus.operand_b = b;
        forever begin
            @(negedge clock);
            if (bus.op_ready) break;
            chk("stall_while_waiting", {31'h0, bus.stall}, 32'h1);
            if (bus.stall) stalls++;
            waited++;
            if (waited > 40) begin
                failures++;
                $display("FAIL accept_timeout op=%0d not accepted after %0d cycles", o, waited);
                finish_run();
            end
        end
        @(posedge clock);
        #1;
        bus.op_valid = 1'b0;
        bus.op       = MDU_NONE;
    endtask

    // Called right after a start op is accepted: counts busy cycles and checks the done pulse.
    task automatic wait_done(input int lat, input string name);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!bus.busy) break;
            n++;
        end
        chk({name, "_busy_cycles"}, 32'(n), 32'(lat));
        chk({name, "_done"}, {31'h0, bus.done}, 32'h1);
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops the scoreboard on every commit and every accepted read.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.done) begin
                if (sbq.size() == 0 || sbq[0].is_read) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=no commit pending at %0t", $time);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("commit_hi", bus.hi, e.hi);
                    chk("commit_lo", bus.lo, e.lo);
                end
            end
            if (bus.op_ready && bus.op_valid &&
                (bus.op == MDU_READ_HI || bus.op == MDU_READ_LO)) begin
                if (sbq.size() == 0 || !sbq[0].is_read) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read actual=%h required=no read pending", bus.read_data);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("read_data", bus.read_data, e.data);
                end
            end else begin
                chk("read_data_idle", bus.read_data, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        mdu_op_e o;
        checks = 0;
        failures = 0;
        m_hi = '0;
        m_lo = '0;
        reset = 1'b0;
        bus.op_valid = 1'b0;
        bus.op = MDU_NONE;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.cancel = 1'b0;
        #2;
        chk("reset_hi", bus.hi, 32'h0);
        chk("reset_lo", bus.lo, 32'h0);
        chk("reset_busy", {31'h0, bus.busy}, 32'h0);
        chk("reset_done", {31'h0, bus.done}, 32'h0);
        chk("reset_stall", {31'h0, bus.stall}, 32'h0);
        chk("reset_op_ready", {31'h0, bus.op_ready}, 32'h0);
        #10 reset = 1'b1;
        @(posedge clock);
        #1;

        // Signed multiply of a negative operand
        issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, st);
        wait_done(MUL_LAT, "mult");

        // MULTU followed by a DIV held until the done cycle
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, st);
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, st);
        chk("div_b2b_stalls", 32'(st), 32'(MUL_LAT));
        wait_done(DIV_LAT, "div");
        chk("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", bus.hi, 32'hFFFF_FFFF);

        // Divide by zero leaves HI/LO untouched
        issue(MDU_WRITE_HI, 32'hAA, 32'h0, 1'b1, st);
        issue(MDU_WRITE_LO, 32'hBB, 32'h0, 1'b1, st);
        issue(MDU_DIVU, 32'h1234, 32'h0, 1'b1, st);
        wait_done(DIV_LAT, "divu_zero");

        // Overflow case INT_MIN / -1
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, st);
        wait_done(DIV_LAT, "div_ovf");
        chk("div_ovf_lo", bus.lo, 32'h8000_0000);
        chk("div_ovf_hi", bus.hi, 32'h0);

        // Read held behind a multiply
        issue(MDU_MULT, 32'd7, 32'hFFFF_FFFE, 1'b1, st);
        issue(MDU_READ_LO, 32'h0, 32'h0, 1'b1, st);
        chk("mflo_stalls", 32'(st), 32'(MUL_LAT));

        // Write then immediate read
        issue(MDU_WRITE_HI, 32'h55, 32'h0, 1'b1, st);
        issue(MDU_READ_HI, 32'h0, 32'h0, 1'b1, st);
        chk("mfhi_no_stall", 32'(st), 32'h0);

        // Cancel an in-flight DIV on its third busy cycle
        issue(MDU_DIV, 32'd100, 32'd7, 1'b0, st);
        @(posedge clock); #1;
        @(posedge clock); #1;
        bus.cancel = 1'b1;
        @(negedge clock);
        chk("cancel_busy_before", {31'h0, bus.busy}, 32'h1);
        @(posedge clock); #1;
        bus.cancel = 1'b0;
        chk("cancel_busy_after", {31'h0, bus.busy}, 32'h0);
        chk("cancel_done", {31'h0, bus.done}, 32'h0);
        chk("cancel_hi", bus.hi, m_hi);
        chk("cancel_lo", bus.lo, m_lo);
        repeat (12) @(posedge clock);
        #1;

        // Cancel while idle drops a write
        bus.op_valid = 1'b1;
        bus.op = MDU_WRITE_HI;
        bus.operand_a = 32'hDEAD_BEEF;
        bus.cancel = 1'b1;
        @(negedge clock);
        chk("idle_cancel_ready", {31'h0, bus.op_ready}, 32'h0);
        @(posedge clock); #1;
        bus.op_valid = 1'b0;
        bus.op = MDU_NONE;
        bus.cancel = 1'b0;
        chk("idle_cancel_hi", bus.hi, m_hi);

        // Asynchronous reset in the middle of a DIV
        issue(MDU_DIV, 32'd1000, 32'd3, 1'b0, st);
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        bus.op_valid = 1'b1;
        bus.op = MDU_READ_HI;
        #1;
        chk("pre_reset_stall", {31'h0, bus.stall}, 32'h1);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        sbq.delete();
        #1;
        chk("midrst_hi", bus.hi, 32'h0);
        chk("midrst_lo", bus.lo, 32'h0);
        chk("midrst_busy", {31'h0, bus.busy}, 32'h0);
        chk("midrst_stall", {31'h0, bus.stall}, 32'h0);
        chk("midrst_done", {31'h0, bus.done}, 32'h0);
        bus.op_valid = 1'b0;
        bus.op = MDU_NONE;
        #2 reset = 1'b1;
        @(posedge clock); #1;
        issue(MDU_MULTU, 32'd9, 32'd9, 1'b1, st);
        chk("post_reset_no_stall", 32'(st), 32'h0);
        wait_done(MUL_LAT, "post_reset");

        // Randomized op stream against the reference model
        for (int i = 0; i < 80; i++) begin
            o = mdu_op_e'(4'($urandom_range(1, 8)));
            issue(o, pick(), pick(), 1'b1, st);
            if (is_start_op(o) && $urandom_range(0, 1) == 1)
                wait_done(is_div_op(o) ? int'(DIV_LAT) : int'(MUL_LAT), "rand");
            else
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clock);
                    #1;
                end
        end

        for (int i = 0; i < 40 && bus.busy; i++) @(posedge clock);
        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
        chk("final_hi", bus.hi, m_hi);
        chk("final_lo", bus.lo, m_lo);
        finish_run();
    end

endmodule
